mini_cpu_datapath: RTL and testbench
====================================

# mini_cpu_datapath

Execution datapath of the mini CPU: consumes the phase strobes and program counter from the CPU phase controller and performs the work for each phase. It holds the instruction memory, instruction register, a 4×8-bit register file, the ALU and the flags. It also checks that the strobes arrive in legal order, so a controller fault is flagged rather than silently corrupting state.

## Interface
- IMEM_DEPTH, 256: instruction memory words; address is `pc` (8 bits), so the maximum is 256.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clock is clk.
- pc  input  8  instruction address, stable from the cycle of `fetch_en` onward.
- fetch_en  input  1  fetch-phase strobe, one cycle.
- decode_en  input  1  decode-phase strobe, one cycle.
- exec_en  input  1  execute-phase strobe, one cycle.
- wb_en  input  1  writeback-phase strobe, one cycle.
- prog_we  input  1  program-load write enable.
- prog_addr  input  8  program-load address.
- prog_data  input  16  program-load data.
- dbg_sel  input  2  register-file debug read select.
- dbg_data  output  8  combinational `rf[dbg_sel]`.
- instr  output  16  current instruction register.
- zero  output  1  zero flag.
- carry  output  1  carry/borrow flag.
- wb_valid  output  1  one-cycle pulse: a register write completed.
- illegal_op  output  1  sticky: undefined opcode executed.
- seq_err  output  1  sticky: strobe protocol violation.

## Operation
- Instruction format: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
- Opcodes:
  - 0 NOP
  - 1 ADD: rd=rd+rs
  - 2 SUB: rd=rd−rs
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 LDI: rd=imm
  - 7 ADDI: rd=rd+imm
  - 8 MOV: rd=rs
  - 9–15: illegal; treated as NOP and set `illegal_op`.
- Phase tracker states: EXP_FETCH → EXP_DECODE → EXP_EXEC → EXP_WB → EXP_FETCH. It advances only on the expected strobe.
- Protocol violations:
  - A strobe other than the expected one, or two or more strobes in the same cycle, sets `seq_err`.
  - All strobes in that cycle are ignored and the tracker does not move.
  - No strobe in a cycle is legal: the tracker holds.
- Fetch: `instr` <= imem[pc].
- Decode:
  - Latch opcode, rd, and operand A = rf[rd].
  - Latch operand B = rf[rs] for ADD/SUB/AND/OR/XOR/MOV; B = imm for LDI/ADDI.
  - Latch the write-enable intent: 1 for opcodes 1–8, 0 otherwise.
- Execute:
  - Compute a 9-bit result; store 8 bits plus a carry bit.
  - ADD/ADDI: carry = bit 8 of A+B.
  - SUB: carry = borrow (A<B unsigned).
  - Logic ops, MOV and LDI: carry = 0.
  - Illegal opcode: set `illegal_op` here.
- Writeback, when write intent is set:
  - rf[rd] <= result.
  - zero <= (result==0); carry <= stored carry.
  - `wb_valid` pulses the following cycle.
- NOP, illegal opcodes: no register or flag change and no `wb_valid`.
- Arithmetic is 8-bit modulo 256: 0xFF+1 = 0x00 with carry=1.
- Program load: `prog_we` writes imem[prog_addr] <= prog_data in any phase. A same-cycle fetch of the same address returns the old word.
- Sticky flags clear only on reset.

## Timing
- Reset values:
  - rf all 0, `instr`=0, `zero`=0, `carry`=0.
  - `wb_valid`=0, `illegal_op`=0, `seq_err`=0, tracker=EXP_FETCH.
  - imem contents are not reset.
- Each phase's register update is visible the cycle after its strobe is sampled.
- `wb_valid` asserts the cycle after `wb_en` and lasts exactly one cycle.
- Minimum instruction latency is 4 strobe cycles. Idle cycles between strobes are permitted at any point.
- Reset mid-instruction:
  - All state returns to reset values immediately.
  - The partially executed instruction has no architectural effect.
  - The next legal strobe is `fetch_en`.
- A write to rd is visible to a decode in the very next instruction, because writeback completes before the next fetch.
- `dbg_data` reflects a writeback in the same cycle `wb_valid` is high.

## Test plan
- Load LDI r1,0x05; LDI r2,0x03; ADD r1,r2, then run 12 in-order strobe cycles -> r1=0x08, zero=0, carry=0, three `wb_valid` pulses.
- LDI r0,0xFF; ADDI r0,0x01 -> r0=0x00, zero=1, carry=1. Then SUB r0,r3 with r3=1 -> r0=0xFF, carry=1 (borrow), zero=0.
- Opcode 0xC at pc 0 -> `illegal_op`=1 after execute, no `wb_valid`, rf unchanged. The next legal instruction still executes.
- Strobe order fetch, exec -> `seq_err`=1, tracker stays EXP_DECODE. A subsequent decode/exec/wb completes the instruction normally. Then fetch+decode in the same cycle -> both ignored.
- Assert reset between decode and exec of ADD r1,r2 -> r1 keeps its reset value 0, all flags 0, and the next fetch is accepted without `seq_err`.
- `prog_we` to address 3 in the same cycle as `fetch_en` with pc=3 -> `instr` holds the old word. The next fetch of pc=3 returns the new word.

Source files
------------

// File: rtl/mini_cpu_datapath.sv
// Execution datapath of the mini CPU: instruction memory, instruction register,
// 4x8-bit register file, ALU and flags, driven by externally supplied phase strobes.
module mini_cpu_datapath #(
  parameter int IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pc,
  input  logic        fetch_en,
  input  logic        decode_en,
  input  logic        exec_en,
  input  logic        wb_en,
  input  logic        prog_we,
  input  logic [7:0]  prog_addr,
  input  logic [15:0] prog_data,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data,
  output logic [15:0] instr,
  output logic        zero,
  output logic        carry,
  output logic        wb_valid,
  output logic        illegal_op,
  output logic        seq_err
);

  typedef enum logic [1:0] {
    EXP_FETCH,
    EXP_DECODE,
    EXP_EXEC,
    EXP_WB
  } phase_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LDI  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_MOV  = 4'd8;

  logic [15:0] imem [IMEM_DEPTH];

  phase_t      phase_q, phase_d;
  logic [15:0] instr_q;
  logic [7:0]  rf_q [4];
  logic [3:0]  opcode_q;
  logic [1:0]  rd_q;
  logic [7:0]  opA_q, opB_q;
  logic        wrIntent_q;
  logic [7:0]  result_q;
  logic        resCarry_q;
  logic        zero_q, carry_q, wbValid_q, illegal_q, seqErr_q;

  logic [2:0]  strobeCount;
  logic        expectedHit;
  logic        strobeLegal, protocolErr;
  logic        fetchGo, decodeGo, execGo, wbGo;

  logic [3:0]  decOp;
  logic [1:0]  decRd, decRs;
  logic [7:0]  decB;
  logic        decIntent;
  logic [8:0]  aluResult;
  logic        execIllegal;

  // A cycle is accepted only when exactly one strobe fires and it is the one the tracker expects.
  always_comb begin
    strobeCount = 3'(fetch_en) + 3'(decode_en) + 3'(exec_en) + 3'(wb_en);
    expectedHit = 1'b0;
    case (phase_q)
      EXP_FETCH:  expectedHit = fetch_en;
      EXP_DECODE: expectedHit = decode_en;
      EXP_EXEC:   expectedHit = exec_en;
      EXP_WB:     expectedHit = wb_en;
      default:    expectedHit = 1'b0;
    endcase
    strobeLegal = (strobeCount == 3'd1) && expectedHit;
    protocolErr = (strobeCount > 3'd1) || ((strobeCount == 3'd1) && !expectedHit);
    fetchGo     = strobeLegal && fetch_en;
    decodeGo    = strobeLegal && decode_en;
    execGo      = strobeLegal && exec_en;
    wbGo        = strobeLegal && wb_en;
  end

  always_comb begin
    phase_d = phase_q;
    if (strobeLegal) begin
      case (phase_q)
        EXP_FETCH:  phase_d = EXP_DECODE;
        EXP_DECODE: phase_d = EXP_EXEC;
        EXP_EXEC:   phase_d = EXP_WB;
        default:    phase_d = EXP_FETCH;
      endcase
    end
  end

  // Operand selection: register-register ops read rs, the immediate forms take imm.
  always_comb begin
    decOp     = instr_q[15:12];
    decRd     = instr_q[11:10];
    decRs     = instr_q[9:8];
    decB      = 8'h00;
    decIntent = (decOp >= OP_ADD) && (decOp <= OP_MOV);
    case (decOp)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: decB = rf_q[decRs];
      OP_LDI, OP_ADDI:                               decB = instr_q[7:0];
      default:                                       decB = 8'h00;
    endcase
  end

  // Bit 8 of the 9-bit subtraction is set exactly when A < B, which is the borrow.
  always_comb begin
    aluResult   = 9'h000;
    execIllegal = opcode_q > OP_MOV;
    case (opcode_q)
      OP_ADD, OP_ADDI: aluResult = {1'b0, opA_q} + {1'b0, opB_q};
      OP_SUB:          aluResult = {1'b0, opA_q} - {1'b0, opB_q};
      OP_AND:          aluResult = {1'b0, opA_q & opB_q};
      OP_OR:           aluResult = {1'b0, opA_q | opB_q};
      OP_XOR:          aluResult = {1'b0, opA_q ^ opB_q};
      OP_LDI, OP_MOV:  aluResult = {1'b0, opB_q};
      default:         aluResult = 9'h000;
    endcase
  end

  // Program memory has no reset; a same-cycle fetch sees the word before this write.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      imem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= EXP_FETCH;
      instr_q    <= 16'h0000;
      opcode_q   <= OP_NOP;
      rd_q       <= 2'd0;
      opA_q      <= 8'h00;
      opB_q      <= 8'h00;
      wrIntent_q <= 1'b0;
      result_q   <= 8'h00;
      resCarry_q <= 1'b0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      wbValid_q  <= 1'b0;
      illegal_q  <= 1'b0;
      seqErr_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= 8'h00;
      end
    end else begin
      phase_q   <= phase_d;
      wbValid_q <= 1'b0;
      if (protocolErr) begin
        seqErr_q <= 1'b1;
      end
      if (fetchGo) begin
        instr_q <= imem[pc];
      end
      if (decodeGo) begin
        opcode_q   <= decOp;
        rd_q       <= decRd;
        opA_q      <= rf_q[decRd];
        opB_q      <= decB;
        wrIntent_q <= decIntent;
      end
      if (execGo) begin
        result_q   <= aluResult[7:0];
        resCarry_q <= aluResult[8];
        if (execIllegal) begin
          illegal_q <= 1'b1;
        end
      end
      if (wbGo && wrIntent_q) begin
        rf_q[rd_q] <= result_q;
        zero_q     <= (result_q == 8'h00);
        carry_q    <= resCarry_q;
        wbValid_q  <= 1'b1;
      end
    end
  end

  assign dbg_data   = rf_q[dbg_sel];
  assign instr      = instr_q;
  assign zero       = zero_q;
  assign carry      = carry_q;
  assign wb_valid   = wbValid_q;
  assign illegal_op = illegal_q;
  assign seq_err    = seqErr_q;

endmodule

// File: tb/tb_mini_cpu_datapath.sv
// Self-checking bench for mini_cpu_datapath: an instruction-level reference model
// checked every cycle, plus hand-computed expectations at key points of the program.
module tb_mini_cpu_datapath;

  logic        clk;
  logic        reset;
  logic [7:0]  pc;
  logic        fetch_en, decode_en, exec_en, wb_en;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;
  logic [15:0] instr;
  logic        zero, carry, wb_valid, illegal_op, seq_err;

  mini_cpu_datapath #(.IMEM_DEPTH(256)) dut (
    .clk(clk), .reset(reset), .pc(pc),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .instr(instr),
    .zero(zero), .carry(carry), .wb_valid(wb_valid),
    .illegal_op(illegal_op), .seq_err(seq_err)
  );

  int checks = 0;
  int failures = 0;
  int wbPulses = 0;
  bit compareOn = 0;

  // Reference model state, updated at instruction-phase granularity.
  logic [15:0] mImem [256];
  logic [7:0]  mRf [4];
  logic [15:0] mInstr;
  int          mPhase;
  logic        mZero, mCarry, mWbValid, mIll, mSeq;
  logic [7:0]  dutRf [4];

  initial begin
    clk = 0;
    forever #10 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPhase = 0; mInstr = 16'h0; mZero = 0; mCarry = 0;
    mWbValid = 0; mIll = 0; mSeq = 0;
    for (int k = 0; k < 4; k++) mRf[k] = 8'h00;
  endtask

  task automatic modelStep();
    int n, s, op, a, b, imm, r;
    logic c;
    n = int'(fetch_en) + int'(decode_en) + int'(exec_en) + int'(wb_en);
    s = fetch_en ? 0 : decode_en ? 1 : exec_en ? 2 : 3;
    mWbValid = 0;
    if (n > 1 || (n == 1 && s != mPhase)) begin
      mSeq = 1;
    end else if (n == 1) begin
      op = int'(mInstr[15:12]);
      if (s == 0) mInstr = mImem[pc];
      if (s == 2 && op >= 9) mIll = 1;
      if (s == 3 && op >= 1 && op <= 8) begin
        a = int'(mRf[mInstr[11:10]]);
        b = int'(mRf[mInstr[9:8]]);
        imm = int'(mInstr[7:0]);
        case (op)
          1: r = a + b;
          2: r = a - b;
          3: r = a & b;
          4: r = a | b;
          5: r = a ^ b;
          6: r = imm;
          7: r = a + imm;
          default: r = b;
        endcase
        c = ((op == 1 || op == 7) && r > 255) || (op == 2 && r < 0);
        r = r & 255;
        mRf[mInstr[11:10]] = 8'(r);
        mZero = (r == 0);
        mCarry = c;
        mWbValid = 1;
      end
      mPhase = (mPhase + 1) % 4;
    end
    if (prog_we) mImem[prog_addr] = prog_data;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) modelReset();
      else modelStep();
    end
  end

  // Compare every cycle, then sweep the debug port over all four registers.
  initial begin
    dbg_sel = 2'd0;
    forever begin
      @(negedge clk);
      if (compareOn) begin
        #1;
        checkOutput("instr", instr, mInstr);
        checkOutput("zero", 16'(zero), 16'(mZero));
        checkOutput("carry", 16'(carry), 16'(mCarry));
        checkOutput("wb_valid", 16'(wb_valid), 16'(mWbValid));
        checkOutput("illegal_op", 16'(illegal_op), 16'(mIll));
        checkOutput("seq_err", 16'(seq_err), 16'(mSeq));
        if (wb_valid === 1'b1) wbPulses++;
        for (int k = 0; k < 4; k++) begin
          dbg_sel = 2'(k);
          #1;
          dutRf[k] = dbg_data;
          checkOutput($sformatf("rf%0d", k), 16'(dbg_data), 16'(mRf[k]));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] strobes, input logic [7:0] pcVal,
                               input logic we, input logic [7:0] addr, input logic [15:0] data);
    @(negedge clk);
    {fetch_en, decode_en, exec_en, wb_en} = strobes;
    pc = pcVal;
    prog_we = we;
    prog_addr = addr;
    prog_data = data;
  endtask

  task automatic idle();
    applyStimulus(4'b0000, pc, 1'b0, 8'h00, 16'h0000);
  endtask

  task automatic loadWord(input logic [7:0] addr, input logic [15:0] data);
    applyStimulus(4'b0000, pc, 1'b1, addr, data);
  endtask

  task automatic runInstr(input logic [7:0] pcVal);
    applyStimulus(4'b1000, pcVal, 1'b0, 8'h00, 16'h0000);
    applyStimulus(4'b0100, pcVal, 1'b0, 8'h00, 16'h0000);
    applyStimulus(4'b0010, pcVal, 1'b0, 8'h00, 16'h0000);
    applyStimulus(4'b0001, pcVal, 1'b0, 8'h00, 16'h0000);
    idle();
  endtask

  // Hand-computed expectation applied to both the DUT snapshot and the model.
  task automatic pinReg(input string name, input int idx, input logic [7:0] exp);
    checkOutput({name, "_dut"}, 16'(dutRf[idx]), 16'(exp));
    checkOutput({name, "_model"}, 16'(mRf[idx]), 16'(exp));
  endtask

  int pulsesBefore;

  initial begin
    reset = 0; pc = 0;
    fetch_en = 0; decode_en = 0; exec_en = 0; wb_en = 0;
    prog_we = 0; prog_addr = 0; prog_data = 0;
    #3 reset = 1;
    compareOn = 1;
    @(negedge clk);
    reset = 0;
    idle();
    #7;
    checkOutput("rst_instr", instr, 16'h0000);
    checkOutput("rst_seq_err", 16'(seq_err), 16'h0);
    for (int k = 0; k < 4; k++) pinReg($sformatf("rst_rf%0d", k), k, 8'h00);

    // LDI r1,5 ; LDI r2,3 ; ADD r1,r2
    loadWord(8'd0, 16'h6405);
    loadWord(8'd1, 16'h6803);
    loadWord(8'd2, 16'h1600);
    idle();
    pulsesBefore = wbPulses;
    runInstr(8'd0);
    runInstr(8'd1);
    runInstr(8'd2);
    #7;
    pinReg("add_r1", 1, 8'h08);
    pinReg("add_r2", 2, 8'h03);
    checkOutput("add_zero", 16'(zero), 16'h0);
    checkOutput("add_carry", 16'(carry), 16'h0);
    checkOutput("add_wb_pulses", 16'(wbPulses - pulsesBefore), 16'd3);

    // LDI r0,FF ; ADDI r0,1 ; LDI r3,1 ; SUB r0,r3
    loadWord(8'd3, 16'h60FF);
    loadWord(8'd4, 16'h7001);
    loadWord(8'd5, 16'h6C01);
    loadWord(8'd6, 16'h2300);
    runInstr(8'd3);
    runInstr(8'd4);
    #7;
    pinReg("wrap_r0", 0, 8'h00);
    checkOutput("wrap_zero", 16'(zero), 16'h1);
    checkOutput("wrap_carry", 16'(carry), 16'h1);
    runInstr(8'd5);
    runInstr(8'd6);
    #7;
    pinReg("sub_r0", 0, 8'hFF);
    checkOutput("sub_borrow", 16'(carry), 16'h1);
    checkOutput("sub_zero", 16'(zero), 16'h0);

    // Illegal opcode at pc 0, then MOV/XOR/OR/AND
    loadWord(8'd0, 16'hC000);
    loadWord(8'd7, 16'h8900);
    loadWord(8'd8, 16'h5500);
    loadWord(8'd9, 16'h4E00);
    loadWord(8'd10, 16'h3C00);
    idle();
    pulsesBefore = wbPulses;
    runInstr(8'd0);
    #7;
    checkOutput("ill_flag", 16'(illegal_op), 16'h1);
    checkOutput("ill_no_wb", 16'(wbPulses - pulsesBefore), 16'd0);
    pinReg("ill_r0", 0, 8'hFF);
    pinReg("ill_r1", 1, 8'h08);
    pinReg("ill_r3", 3, 8'h01);
    runInstr(8'd7);
    #7;
    pinReg("mov_r2", 2, 8'h08);
    runInstr(8'd8);
    #7;
    pinReg("xor_r1", 1, 8'h00);
    checkOutput("xor_zero", 16'(zero), 16'h1);
    runInstr(8'd9);
    runInstr(8'd10);
    #7;
    pinReg("or_and_r3", 3, 8'h09);

    // Out-of-order strobe, recovery, then simultaneous strobes
    applyStimulus(4'b1000, 8'd2, 1'b0, 8'h00, 16'h0000);
    applyStimulus(4'b0010, 8'd2, 1'b0, 8'h00, 16'h0000);
    idle();
    #7;
    checkOutput("seq_err_set", 16'(seq_err), 16'h1);
    applyStimulus(4'b0100, 8'd2, 1'b0, 8'h00, 16'h0000);
    applyStimulus(4'b0010, 8'd2, 1'b0, 8'h00, 16'h0000);
    applyStimulus(4'b0001, 8'd2, 1'b0, 8'h00, 16'h0000);
    idle();
    #7;
    pinReg("recover_r1", 1, 8'h08);
    applyStimulus(4'b1100, 8'd1, 1'b0, 8'h00, 16'h0000);
    idle();
    runInstr(8'd1);
    #7;
    pinReg("after_dual_r2", 2, 8'h03);
    checkOutput("seq_err_sticky", 16'(seq_err), 16'h1);

    // Reset between decode and execute of ADD r1,r2
    applyStimulus(4'b1000, 8'd2, 1'b0, 8'h00, 16'h0000);
    applyStimulus(4'b0100, 8'd2, 1'b0, 8'h00, 16'h0000);
    idle();
    reset = 1;
    idle();
    reset = 0;
    #7;
    pinReg("midrst_r1", 1, 8'h00);
    checkOutput("midrst_seq_err", 16'(seq_err), 16'h0);
    checkOutput("midrst_illegal", 16'(illegal_op), 16'h0);
    checkOutput("midrst_carry", 16'(carry), 16'h0);
    applyStimulus(4'b1000, 8'd2, 1'b0, 8'h00, 16'h0000);
    idle();
    #7;
    checkOutput("midrst_fetch_ok", 16'(seq_err), 16'h0);
    checkOutput("midrst_instr", instr, 16'h1600);
    applyStimulus(4'b0100, 8'd2, 1'b0, 8'h00, 16'h0000);
    applyStimulus(4'b0010, 8'd2, 1'b0, 8'h00, 16'h0000);
    applyStimulus(4'b0001, 8'd2, 1'b0, 8'h00, 16'h0000);
    idle();
    #7;
    checkOutput("midrst_add_zero", 16'(zero), 16'h1);

    // Program write racing a fetch of the same address
    applyStimulus(4'b1000, 8'd3, 1'b1, 8'd3, 16'h6C42);
    idle();
    #7;
    checkOutput("race_old_word", instr, 16'h60FF);
    applyStimulus(4'b0100, 8'd3, 1'b0, 8'h00, 16'h0000);
    applyStimulus(4'b0010, 8'd3, 1'b0, 8'h00, 16'h0000);
    applyStimulus(4'b0001, 8'd3, 1'b0, 8'h00, 16'h0000);
    idle();
    runInstr(8'd3);
    #7;
    checkOutput("race_new_word", instr, 16'h6C42);
    pinReg("race_r0", 0, 8'hFF);
    pinReg("race_r3", 3, 8'h42);

    idle();
    idle();
    compareOn = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
